// File: rtl/hamming_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// hamming_accumulator_pkg
// Shared constants for the Hamming-distance accumulator:
//   - bit_length(): number of bits needed to hold a value (the popcount width)
//   - state encoding of the accumulator FSM (IDLE=0, ACCUM=1, HOLD=2)
// No ports.
// -----------------------------------------------------------------------------
package hamming_accumulator_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_ACCUM = ACCUM,
      ST_HOLD  = HOLD
   } state_e;

   // Bit-length of a non-negative value: 0 -> 0, 1 -> 1, 8 -> 4, 32 -> 6.
   // A popcount of an N-bit word ranges 0..N, so it needs bit_length(N) bits.
   function automatic int bit_length(input int value);
      int n;
      n = 0;
      for (int i = 0; i < 31; i++) begin
         if ((value >> i) != 0) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/hamming_accumulator_count.sv
// -----------------------------------------------------------------------------
// hamming_accumulator_count
// Combinational N-bit population counter.
// Ports:
//   data_i  [N-1:0]  word to count
//   count_o [CW-1:0] number of set bits in data_i, CW = bit_length(N)
// -----------------------------------------------------------------------------
module hamming_accumulator_count
   import hamming_accumulator_pkg::*;
#(
   parameter int N = 32,
   localparam int CW = bit_length(N)
) (
   input  logic [N-1:0]  data_i,
   output logic [CW-1:0] count_o
);

   // NOTE: every signal written in always_comb gets a value before any
   // conditional logic, otherwise synthesis infers a latch to hold it.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < N; i++) begin
         count_o = count_o + CW'(data_i[i]);
      end
   end

endmodule

// File: rtl/hamming_accumulator.sv
// -----------------------------------------------------------------------------
// hamming_accumulator
// Accumulates the Hamming distance between operand words over a framed
// sequence of beats into a saturating accumulator and presents the total on
// a valid/ready output port.
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   start      opens a frame (honoured only in IDLE)
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (high in ACCUM)
//   a, b       operand words [N-1:0]
//   last       final beat of the frame, qualified by in_valid & in_ready
//   out_valid  result valid (high in HOLD)
//   out_ready  downstream consumes the result
//   sum        accumulated distance [ACC_W-1:0]
//   sat        sticky saturation flag
// Outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module hamming_accumulator
   import hamming_accumulator_pkg::*;
#(
   parameter int N     = 32,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] sum,
   output logic             sat
);

   localparam int CW = bit_length(N);

   generate
      if (N < 1) begin : g_bad_n
         $error("hamming_accumulator: N must be at least 1");
      end
      if (ACC_W < CW) begin : g_bad_acc_w
         $error("hamming_accumulator: ACC_W must be at least bit_length(N)");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             sat_q, sat_d;

   logic [CW-1:0]    cnt;
   logic [ACC_W:0]   sum_wide;
   logic             beat_fire;

   hamming_accumulator_count #(.N(N)) u_count (
      .data_i  (a ^ b),
      .count_o (cnt)
   );

   // One guard bit above the accumulator catches the overflow of a single add.
   assign sum_wide  = {1'b0, acc_q} + {{(ACC_W + 1 - CW){1'b0}}, cnt};
   assign beat_fire = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d   = '0;
               sat_d   = 1'b0;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (beat_fire) begin
               // Once saturated, acc is all-ones and any add overflows or adds
               // zero, so the clip below keeps it pinned without extra logic.
               if (sum_wide[ACC_W]) begin
                  acc_d = '1;
                  sat_d = 1'b1;
               end else begin
                  acc_d = sum_wide[ACC_W-1:0];
               end
               if (last) state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, matching real hardware.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
      end
   end

   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_HOLD);
   assign sum       = acc_q;
   assign sat       = sat_q;

endmodule

// File: doc/hamming_accumulator.md
# hamming_accumulator

Sequential Hamming-distance accumulator sitting directly downstream of the combinational N-bit population counter. Each accepted beat XORs two N-bit operand words, popcounts the difference through one `COUNT` instance, and adds the count into a saturating accumulator. The total for a framed sequence of beats is presented on a valid/ready output port. Used by Hamming/threshold garbled-circuit benchmarks that compare vectors longer than one word.

## Interface
- `N`, default 32: operand word width in bits; N ≥ 1.
- `ACC_W`, default 16: accumulator width in bits. Requires ACC_W ≥ CW, where CW = bit-length of N (the `COUNT` output width). Violation is an elaboration error.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that opens a frame. Honoured only in IDLE.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `a` in N: operand A.
- `b` in N: operand B.
- `last` in 1: qualifies the final beat of the frame; sampled with `in_valid & in_ready`.
- `out_valid` out 1: result valid; held until it is consumed.
- `out_ready` in 1: downstream consumes the result.
- `sum` out ACC_W: accumulated Hamming distance.
- `sat` out 1: sticky flag, set when the accumulator clipped.

## Operation
- Three states: IDLE, ACCUM, HOLD. Outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 clears the accumulator and `sat`, then moves to ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - On `in_valid & in_ready`: cnt = popcount(`a`^`b`), acc ← acc + cnt, with cnt zero-extended to ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W−1, acc becomes all-ones and `sat` is set.
  - If `last`=1 on that beat, move to HOLD.
  - `in_valid`=0 cycles leave all state unchanged.
  - `start` is ignored.
- **HOLD**
  - `out_valid`=1 and `in_ready`=0; `sum`=acc.
  - `out_ready`=1 moves to IDLE.
  - `sum` and `sat` stay stable while `out_valid` is high and retain their value after the handshake until the next `start`.
- `sat` is sticky. Once set, later beats keep acc at all-ones.
- A frame has at least one beat. An empty frame is not expressible.

## Timing
- Reset values: state IDLE, acc=0, `sat`=0, `in_ready`=0, `out_valid`=0, `sum`=0.
- `start` at cycle t gives `in_ready`=1 at t+1.
- Accumulation latency is one cycle: a beat accepted at t is reflected in acc at t+1.
- A last beat accepted at t gives `out_valid`=1 at t+1, with `sum` final.
- Output handshake at t gives `out_valid`=0 and IDLE at t+1. The earliest new `start` is honoured at t+1; a `start` coinciding with the handshake is ignored.
- Simultaneous `rst` with any other input: reset wins.
- Reset mid-frame discards the partial sum; the block returns to IDLE with reset values on the next edge.
- Worst-case throughput: one beat per cycle in ACCUM. Per-frame overhead is 2 cycles (start→ACCUM, HOLD→IDLE) plus the downstream stall.

## Structure
- Shared constants in the common syn_lib header:
  - the bit-length function (used for CW);
  - the state encoding localparams (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2).
- One sub-module: `COUNT` with parameter N=N, driven by `a`^`b`. Its CW-bit output feeds the saturating adder.
- The saturating add and the FSM are inline in this module.

## Test plan
All scenarios use N=8, ACC_W=6.
- **Reset:** assert `rst` 2 cycles with random inputs -> `in_ready`=0, `out_valid`=0, `sum`=0, `sat`=0.
- **Basic frame:** `start`; beats (8'hFF,8'h00), (8'h0F,8'h01), then last (8'hAA,8'hAA) -> the cycle after the last beat `out_valid`=1, `sum`=11, `sat`=0.
- **Saturation:** 8 beats of (8'hFF,8'h00), last on the 8th -> acc=56 after 7 beats; final `sum`=63, `sat`=1.
- **Gaps and backpressure:**
  - Frame with `in_valid` low on alternate cycles, beats (8'h03,8'h00)×3 -> `sum`=6.
  - Hold `out_ready`=0 for 5 cycles -> `sum`/`out_valid` stable, `in_ready`=0.
  - `start` pulsed during HOLD -> ignored.
- **Reset mid-frame:** 2 beats of (8'hFF,8'h00), then `rst` -> IDLE next cycle. A new frame with a single last beat (8'h01,8'h00) -> `sum`=1.
- **Handshake/start collision:** `out_ready`=1 and `start`=1 in the same HOLD cycle -> IDLE, with no new frame opened. `start` on the following cycle -> ACCUM.
